wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port (reg_write / rd / rd_data) between two writeback requesters: the ALU pipe (requester A) and the load/store unit (requester L).
- Each requester has a one-entry holding slot with a valid/ready handshake.
- Grants one slot per cycle to the register file using oldest-first order, with a round-robin tie-break.
- Exports a pending-destination mask for hazard logic and a saturating conflict counter.

Parameters:
- XLEN, 32, data width of write data
- RADDR_W, 5, register address width
- CNT_W, 16, width of the conflict counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-low: state clears on a rising clk edge while rst==0
- a_valid  in  1  ALU writeback request
- a_ready  out  1  ALU slot can accept this cycle
- a_rd  in  RADDR_W  ALU destination register
- a_data  in  XLEN  ALU result
- l_valid  in  1  LSU writeback request
- l_ready  out  1  LSU slot can accept this cycle
- l_rd  in  RADDR_W  LSU destination register
- l_data  in  XLEN  LSU load data
- reg_write  out  1  write enable to the register file
- rd  out  RADDR_W  destination register to the register file
- rd_data  out  XLEN  write data to the register file
- pending_mask  out  32  bit i set when either full slot holds rd==i, with i!=0
- conflict_cnt  out  CNT_W  count of cycles in which both slots were full

Behaviour:
- State:
  - slot_a and slot_l, each {full, rd, data}
  - older: 0 = A older, 1 = L older; meaningful only when both slots are full
  - rr: tie-break pointer, 0 = favour A, 1 = favour L
  - conflict_cnt
- Reset (rst==0 at a clk edge):
  - both slots empty; older=0, rr=0, conflict_cnt=0
  - combinational consequences: reg_write=0, rd=0, rd_data=0, pending_mask=0, a_ready=1, l_ready=1
- Handshake and acceptance:
  - A transfer occurs when valid && ready at a clk edge.
  - x_ready = !slot_x.full || grant_x. A slot drained this cycle may be refilled in the same cycle.
  - Accepted data is captured into the slot at the edge.
- Grant, combinational and evaluated on the current slot state:
  - only one slot full -> grant that slot
  - both full, and they did not fill at the same edge -> grant the slot indicated by `older`
  - both full and filled at the same edge -> grant per rr; rr then toggles to the other requester
- Write-port outputs:
  - rd and rd_data are driven from the granted slot; both are 0 when no slot is full.
  - reg_write = (a slot is granted) && (granted rd != 0).
  - A granted entry with rd==0 is consumed and discarded without a write.
- Latency: a request accepted at edge N is written at edge N+1 if uncontested, otherwise at N+2.
- Throughput: at most one register write per cycle.
- `older` update:
  - If one slot is filled while the other stays full and ungranted, the non-filling slot becomes older.
  - If both slots fill at the same edge, a same-edge tie flag is set and the tie is resolved by rr.
- Ordering guarantee: two entries to the same rd drain in acceptance order; same-edge acceptance drains in rr order. Upstream must not issue same-edge writes to the same rd.
- pending_mask:
  - combinational from full slots, including a slot that is granted this cycle
  - bit 0 is always 0
- conflict_cnt: increments on every edge where both slots are full; saturates at all-ones and does not wrap.
- No combinational path from a_valid or l_valid to reg_write. Outputs depend on slot state only.
- Reset mid-operation: pending entries are dropped and no write occurs on the reset edge's following cycle.

Test Plan:
- Reset, then single A write: a_rd=5, a_data=0x1234 accepted at edge 1 -> reg_write=1, rd=5, rd_data=0x1234 during cycle 2; pending_mask=0x20 in cycle 2, then 0.
- Simultaneous A(rd=3, 0xA) and L(rd=4, 0xB) after reset (rr=0) -> cycle 2 writes rd=3 and cycle 3 writes rd=4; conflict_cnt=1; a fresh simultaneous pair then writes L first.
- Age order: L(rd=7) accepted at edge 1, A(rd=7) at edge 2 while L is still held -> L data written first, then A; final register value is A's data.
- Back-to-back A stream with a_valid held for 8 cycles and L idle -> a_ready stays 1 and there are 8 consecutive writes with no bubbles.
- rd==0: A request with rd=0, data=0xFFFF -> reg_write stays 0; slot drains in 1 cycle; pending_mask stays 0.
- Reset mid-operation: both slots full, rst=0 for one edge -> cycle after: reg_write=0, pending_mask=0, conflict_cnt=0, both ready=1.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: two one-entry holding slots (ALU, LSU) share the single register-file
// write port, draining oldest-first with a round-robin tie-break for same-edge arrivals.
module wb_port_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [RADDR_W-1:0] a_rd,
  input  logic [XLEN-1:0]    a_data,
  input  logic               l_valid,
  output logic               l_ready,
  input  logic [RADDR_W-1:0] l_rd,
  input  logic [XLEN-1:0]    l_data,
  output logic               reg_write,
  output logic [RADDR_W-1:0] rd,
  output logic [XLEN-1:0]    rd_data,
  output logic [31:0]        pending_mask,
  output logic [CNT_W-1:0]   conflict_cnt
);

  logic               a_full_q, l_full_q;
  logic [RADDR_W-1:0] a_rd_q, l_rd_q;
  logic [XLEN-1:0]    a_data_q, l_data_q;
  logic               older_q;  // 1: L slot holds the older entry
  logic               tie_q;    // both slots were filled at the same edge
  logic               rr_q;     // 1: favour L on a tie
  logic [CNT_W-1:0]   cnt_q;

  logic both_full, pick_l, grant_a, grant_l, a_acc, l_acc;

  always_comb begin
    both_full = a_full_q & l_full_q;
    pick_l    = tie_q ? rr_q : older_q;
    grant_a   = a_full_q & (~l_full_q | ~pick_l);
    grant_l   = l_full_q & (~a_full_q | pick_l);
    a_ready   = ~a_full_q | grant_a;
    l_ready   = ~l_full_q | grant_l;
    a_acc     = a_valid & a_ready;
    l_acc     = l_valid & l_ready;
  end

  // Write port is driven purely from slot state; rd==0 entries drain without a write.
  always_comb begin
    rd      = '0;
    rd_data = '0;
    if (grant_a) begin
      rd      = a_rd_q;
      rd_data = a_data_q;
    end else if (grant_l) begin
      rd      = l_rd_q;
      rd_data = l_data_q;
    end
    reg_write = (grant_a | grant_l) && (rd != '0);
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((a_full_q && 32'(a_rd_q) == i) || (l_full_q && 32'(l_rd_q) == i)) begin
        pending_mask[i] = 1'b1;
      end
    end
  end

  assign conflict_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_full_q <= 1'b0;
      l_full_q <= 1'b0;
      a_rd_q   <= '0;
      l_rd_q   <= '0;
      a_data_q <= '0;
      l_data_q <= '0;
      older_q  <= 1'b0;
      tie_q    <= 1'b0;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (a_acc) begin
        a_full_q <= 1'b1;
        a_rd_q   <= a_rd;
        a_data_q <= a_data;
      end else if (grant_a) begin
        a_full_q <= 1'b0;
      end

      if (l_acc) begin
        l_full_q <= 1'b1;
        l_rd_q   <= l_rd;
        l_data_q <= l_data;
      end else if (grant_l) begin
        l_full_q <= 1'b0;
      end

      // The slot that did not fill becomes the older one; only matters if it stays full.
      if (a_acc && l_acc) begin
        tie_q <= 1'b1;
      end else if (a_acc) begin
        tie_q   <= 1'b0;
        older_q <= 1'b1;
      end else if (l_acc) begin
        tie_q   <= 1'b0;
        older_q <= 1'b0;
      end

      if (both_full && tie_q) begin
        rr_q <= ~rr_q;
      end

      if (both_full && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus hand-built contention, stream,
// saturation and mid-operation reset sequences; writes are checked against a scoreboard queue.
module tb_wb_port_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, l_valid, a_ready, l_ready, reg_write;
  logic [RW-1:0]   a_rd, l_rd, rd;
  logic [XLEN-1:0] a_data, l_data, rd_data;
  logic [31:0]     pending_mask;
  logic [CW-1:0]   conflict_cnt;

  wb_port_arbiter #(.XLEN(XLEN), .RADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
    .reg_write(reg_write), .rd(rd), .rd_data(rd_data),
    .pending_mask(pending_mask), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        l_first;
    logic [31:0] mask1;
    logic [31:0] mask2;
    logic        cnt_inc;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   wr_seen = 0;
  int   exp_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.rd   = r;
    e.data = d;
    if (r != 5'd0) exp_q.push_back(e);
  endtask

  // Observe the write port once per cycle, just after the edge has settled.
  task automatic mon();
    wr_t e;
    if (mon_en && reg_write === 1'b1) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rd, rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("write_rd", 32'(rd), 32'(e.rd));
        chk("write_data", rd_data, e.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    l_valid = 1'b0; l_rd = '0; l_data = '0;
  endtask

  initial begin
    int wr0;
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    mon_en = 1'b1;

    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_a_ready", 32'(a_ready), 1);
    chk("rst_l_ready", 32'(l_ready), 1);
    chk("rst_cnt", 32'(conflict_cnt), 0);

    tbl[0] = '{1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,  1'b0, 32'h20,        32'h0,        1'b0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'h99, 1'b0, 32'h200,       32'h0,        1'b0};
    tbl[2] = '{1'b1, 5'd3,  32'hA,    1'b1, 5'd4,  32'hB,  1'b0, 32'h18,        32'h10,       1'b1};
    tbl[3] = '{1'b1, 5'd10, 32'hC,    1'b1, 5'd11, 32'hD,  1'b1, 32'hC00,       32'h400,      1'b1};
    tbl[4] = '{1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0,  32'h0,  1'b0, 32'h0,         32'h0,        1'b0};
    tbl[5] = '{1'b1, 5'd0,  32'h1,    1'b1, 5'd6,  32'h66, 1'b0, 32'h40,        32'h40,       1'b1};
    tbl[6] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'h5,  1'b0, 32'h0,         32'h0,        1'b0};
    tbl[7] = '{1'b1, 5'd31, 32'h31,   1'b1, 5'd1,  32'h1,  1'b1, 32'h8000_0002, 32'h8000_0000, 1'b1};

    for (int i = 0; i < 8; i++) begin
      a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].ad;
      l_valid = tbl[i].lv; l_rd = tbl[i].lrd; l_data = tbl[i].ld;
      chk("vec_a_ready", 32'(a_ready), 1);
      chk("vec_l_ready", 32'(l_ready), 1);
      if (tbl[i].av && tbl[i].lv && tbl[i].l_first) begin
        push(tbl[i].lrd, tbl[i].ld);
        push(tbl[i].ard, tbl[i].ad);
      end else begin
        if (tbl[i].av) push(tbl[i].ard, tbl[i].ad);
        if (tbl[i].lv) push(tbl[i].lrd, tbl[i].ld);
      end
      step();
      idle_inputs();
      chk("vec_mask_accept", pending_mask, tbl[i].mask1);
      step();
      chk("vec_mask_drain", pending_mask, tbl[i].mask2);
      step();
      step();
      if (tbl[i].cnt_inc) exp_cnt++;
      chk("vec_cnt", 32'(conflict_cnt), 32'(exp_cnt));
      chk("vec_mask_empty", pending_mask, 0);
      chk("vec_sb_empty", 32'(exp_q.size()), 0);
    end

    // Age order overrides the tie-break once one slot has been refilled.
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'hA1;
    l_valid = 1'b1; l_rd = 5'd8; l_data = 32'hB1;
    push(5'd7, 32'hA1);
    push(5'd8, 32'hB1);
    step();
    a_rd = 5'd8; a_data = 32'hA2; l_valid = 1'b0;
    chk("age_l_ready_held", 32'(l_ready), 0);
    chk("age_a_ready", 32'(a_ready), 1);
    push(5'd8, 32'hA2);
    step();
    a_valid = 1'b0; l_valid = 1'b1; l_rd = 5'd7; l_data = 32'hB2;
    chk("age_mask_same_rd", pending_mask, 32'h100);
    chk("age_a_ready_held", 32'(a_ready), 0);
    chk("age_l_ready", 32'(l_ready), 1);
    push(5'd7, 32'hB2);
    step();
    idle_inputs();
    chk("age_mask_both", pending_mask, 32'h180);
    step();
    step();
    exp_cnt += 3;
    chk("age_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    chk("age_sb_empty", 32'(exp_q.size()), 0);

    // Back-to-back ALU stream with no bubbles.
    wr0 = wr_seen;
    for (int k = 0; k < 8; k++) begin
      a_valid = 1'b1; a_rd = 5'(k + 1); a_data = 32'h100 + 32'(k);
      chk("stream_a_ready", 32'(a_ready), 1);
      push(a_rd, a_data);
      step();
    end
    idle_inputs();
    chk("stream_writes", 32'(wr_seen - wr0), 8);
    step();
    chk("stream_sb_empty", 32'(exp_q.size()), 0);

    // Saturation: keep both slots contending with rd==0 entries (no writes).
    a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF;
    l_valid = 1'b1; l_rd = 5'd0; l_data = 32'hEEEE;
    repeat (5) step();
    chk("sat_cnt_mid", 32'(conflict_cnt), 32'(exp_cnt + 4));
    chk("sat_no_mask", pending_mask, 0);
    repeat (15) step();
    chk("sat_cnt_hold", 32'(conflict_cnt), 32'hF);
    idle_inputs();
    repeat (3) step();
    chk("sat_cnt_final", 32'(conflict_cnt), 32'hF);

    // Reset with both slots full drops the pending entries.
    a_valid = 1'b1; a_rd = 5'd20; a_data = 32'h20;
    l_valid = 1'b1; l_rd = 5'd0;  l_data = 32'h21;
    push(5'd20, 32'h20);
    step();
    idle_inputs();
    chk("mid_mask", pending_mask, 32'h0010_0000);
    exp_q.delete();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_reg_write", 32'(reg_write), 0);
    chk("mid_pending", pending_mask, 0);
    chk("mid_cnt", 32'(conflict_cnt), 0);
    chk("mid_a_ready", 32'(a_ready), 1);
    chk("mid_l_ready", 32'(l_ready), 1);
    step();
    chk("mid_idle_write", 32'(reg_write), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
